// File: rtl/rename_map_ckpt.sv
// Speculative register alias table with branch checkpoints.
// Intra-group bypass on reads, one snapshot per cycle, one-cycle restore.
module rename_map_ckpt #(
  parameter  int CREG_NUM     = 32,
  parameter  int PREG_NUM     = 64,
  parameter  int RENAME_WIDTH = 2,
  parameter  int COMMIT_WIDTH = 2,
  parameter  int CKPT_NUM     = 4,
  localparam int CW = $clog2(CREG_NUM),
  localparam int PW = $clog2(PREG_NUM),
  localparam int SW = (RENAME_WIDTH > 1) ? $clog2(RENAME_WIDTH) : 1,
  localparam int KW = $clog2(CKPT_NUM)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [RENAME_WIDTH-1:0]        ren_valid,
  input  logic [RENAME_WIDTH-1:0]        ren_wen,
  input  logic [RENAME_WIDTH*CW-1:0]     ren_dst,
  input  logic [RENAME_WIDTH*PW-1:0]     ren_pdst,
  input  logic [RENAME_WIDTH*CW-1:0]     ren_src1,
  input  logic [RENAME_WIDTH*CW-1:0]     ren_src2,
  output logic [RENAME_WIDTH*(PW+1)-1:0] ren_psrc1,
  output logic [RENAME_WIDTH*(PW+1)-1:0] ren_psrc2,
  input  logic                           ckpt_req,
  input  logic [SW-1:0]                  ckpt_slot,
  output logic [KW-1:0]                  ckpt_id,
  output logic                           ckpt_full,
  input  logic [COMMIT_WIDTH-1:0]        cm_valid,
  input  logic [COMMIT_WIDTH*CW-1:0]     cm_dst,
  input  logic [COMMIT_WIDTH*PW-1:0]     cm_preg,
  input  logic                           ckpt_release,
  input  logic                           restore_valid,
  input  logic [KW-1:0]                  restore_id,
  input  logic                           flush
);

  localparam logic [KW:0] ONE  = (KW+1)'(1);
  localparam logic [KW:0] FULL = (KW+1)'(CKPT_NUM);

  logic [CW-1:0] dst  [RENAME_WIDTH];
  logic [PW-1:0] pdst [RENAME_WIDTH];
  logic [CW-1:0] src  [2][RENAME_WIDTH];
  logic [RENAME_WIDTH-1:0] wr;

  logic [CREG_NUM-1:0] spec_v_q, spec_v_d;
  logic [PW-1:0]       spec_p_q [CREG_NUM];
  logic [PW-1:0]       spec_p_d [CREG_NUM];
  logic [CREG_NUM-1:0] ck_v_q [CKPT_NUM];
  logic [CREG_NUM-1:0] ck_v_d [CKPT_NUM];
  logic [PW-1:0]       ck_p_q [CKPT_NUM][CREG_NUM];
  logic [PW-1:0]       ck_p_d [CKPT_NUM][CREG_NUM];
  logic [KW:0]         head_q, head_d;
  logic [KW:0]         tail_q, tail_d;
  logic                full_q, full_d;

  logic [CREG_NUM-1:0] snap_v;
  logic [PW-1:0]       snap_p [CREG_NUM];
  logic [CKPT_NUM-1:0] alloc;
  logic                save;
  logic                rel;
  logic [KW:0]         cnt;
  logic [KW:0]         rptr;
  logic [KW-1:0]       roff;

  // True when some commit port retires exactly this {valid, preg} mapping.
  function automatic logic cm_hit(
    input logic [CW-1:0]              c,
    input logic                       v,
    input logic [PW-1:0]              p,
    input logic [COMMIT_WIDTH-1:0]    cv,
    input logic [COMMIT_WIDTH*CW-1:0] cd,
    input logic [COMMIT_WIDTH*PW-1:0] cp
  );
    cm_hit = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (cv[k] && v && c != '0 &&
          cd[k*CW +: CW] == c && cp[k*PW +: PW] == p)
        cm_hit = 1'b1;
    end
  endfunction

  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      dst[i]    = ren_dst[i*CW +: CW];
      pdst[i]   = ren_pdst[i*PW +: PW];
      src[0][i] = ren_src1[i*CW +: CW];
      src[1][i] = ren_src2[i*CW +: CW];
      wr[i]     = ren_valid[i] & ren_wen[i];
    end
  end

  always_comb begin : p_read
    logic          v;
    logic [PW-1:0] p;
    ren_psrc1 = '0;
    ren_psrc2 = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        v = spec_v_q[src[s][i]];
        p = spec_p_q[src[s][i]];
        for (int j = 0; j < i; j++) begin
          if (wr[j] && dst[j] == src[s][i]) begin
            v = 1'b1;
            p = pdst[j];
          end
        end
        if (src[s][i] == '0) v = 1'b0;
        if (s == 0) ren_psrc1[i*(PW+1) +: PW+1] = v ? {1'b1, p} : '0;
        else        ren_psrc2[i*(PW+1) +: PW+1] = v ? {1'b1, p} : '0;
      end
    end
  end

  always_comb begin : p_next
    logic [KW-1:0] off;
    cnt  = tail_q - head_q;
    save = ckpt_req & ~full_q & ~flush & ~restore_valid;
    rel  = ckpt_release & (head_q != tail_q);
    roff = restore_id - head_q[KW-1:0];
    rptr = head_q + {1'b0, roff};
    spec_v_d = spec_v_q;
    spec_p_d = spec_p_q;
    snap_v   = spec_v_q;
    snap_p   = spec_p_q;
    ck_v_d   = ck_v_q;
    ck_p_d   = ck_p_q;
    head_d   = head_q;
    tail_d   = tail_q;
    alloc    = '0;
    off      = '0;

    for (int c = 0; c < CREG_NUM; c++) begin
      if (cm_hit(CW'(c), spec_v_q[c], spec_p_q[c],
                 cm_valid, cm_dst, cm_preg))
        spec_v_d[c] = 1'b0;
    end

    for (int i = 0; i < RENAME_WIDTH; i++) begin
      if (wr[i] && dst[i] != '0) begin
        spec_v_d[dst[i]] = 1'b1;
        spec_p_d[dst[i]] = pdst[i];
        if (SW'(i) <= ckpt_slot) begin
          snap_v[dst[i]] = 1'b1;
          snap_p[dst[i]] = pdst[i];
        end
      end
    end

    for (int c = 0; c < CREG_NUM; c++) begin
      if (cm_hit(CW'(c), snap_v[c], snap_p[c],
                 cm_valid, cm_dst, cm_preg))
        snap_v[c] = 1'b0;
    end

    for (int s = 0; s < CKPT_NUM; s++) begin
      off      = KW'(s) - head_q[KW-1:0];
      alloc[s] = {1'b0, off} < cnt;
      for (int c = 0; c < CREG_NUM; c++) begin
        if (alloc[s] && cm_hit(CW'(c), ck_v_q[s][c], ck_p_q[s][c],
                               cm_valid, cm_dst, cm_preg))
          ck_v_d[s][c] = 1'b0;
      end
    end

    if (rel) head_d = head_q + ONE;

    if (restore_valid) begin
      spec_v_d = ck_v_d[restore_id];
      for (int c = 0; c < CREG_NUM; c++)
        spec_p_d[c] = ck_p_q[restore_id][c];
      tail_d = rptr + ONE;
    end else if (save) begin
      ck_v_d[tail_q[KW-1:0]] = snap_v;
      for (int c = 0; c < CREG_NUM; c++)
        ck_p_d[tail_q[KW-1:0]][c] = snap_p[c];
      tail_d = tail_q + ONE;
    end

    // Stale checkpoint contents are unreachable once the pointers reset.
    if (flush) begin
      spec_v_d = '0;
      spec_p_d = spec_p_q;
      ck_v_d   = ck_v_q;
      ck_p_d   = ck_p_q;
      head_d   = '0;
      tail_d   = '0;
    end

    full_d = (tail_d - head_d) == FULL;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      spec_v_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      full_q   <= 1'b0;
      for (int c = 0; c < CREG_NUM; c++) spec_p_q[c] <= '0;
      for (int s = 0; s < CKPT_NUM; s++) begin
        ck_v_q[s] <= '0;
        for (int c = 0; c < CREG_NUM; c++) ck_p_q[s][c] <= '0;
      end
    end else begin
      spec_v_q <= spec_v_d;
      spec_p_q <= spec_p_d;
      ck_v_q   <= ck_v_d;
      ck_p_q   <= ck_p_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      full_q   <= full_d;
    end
  end

  assign ckpt_id   = tail_q[KW-1:0];
  assign ckpt_full = full_q;

`ifndef SYNTHESIS
  a_ckpt_ovf: assert property (@(posedge clk) disable iff (!resetn)
    !(ckpt_req && full_q));
  a_rel_empty: assert property (@(posedge clk) disable iff (!resetn)
    !(ckpt_release && !flush && head_q == tail_q));
  a_rst_alloc: assert property (@(posedge clk) disable iff (!resetn)
    !(restore_valid && !flush && !alloc[restore_id]));
`endif

endmodule
